// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_bus_arbiter
// Description : Round-robin arbiter for the shared system bus. It issues a
//               registered one-hot grant, inserts a turnaround gap after
//               every release, and rotates priority so that the master just
//               served ranks lowest in the next round.
//               Optional feature macro ARB_TIMEOUT_EN: when defined, a grant
//               that lasts MAX_HOLD cycles is revoked and timeout_o pulses.
// Revision    : 1.0  initial release
// ============================================================================
module rr_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int OW = $clog2(N_REQ);
    // One extra bit so last+i can be formed before folding back into range
    localparam int IW = OW + 1;
    localparam int TW = 3;

    localparam logic [IW-1:0]    C_N         = IW'(N_REQ);
    localparam logic [OW-1:0]    C_LAST_RST  = OW'(N_REQ - 1);
    localparam logic [TW-1:0]    C_TURN_LAST = TW'(TURNAROUND - 1);
    localparam logic [N_REQ-1:0] C_ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

    // Parameter legality is checked at elaboration so a bad build never links
    if (N_REQ < 2 || N_REQ > 8 || TURNAROUND < 1 || TURNAROUND > 7 ||
        MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("rr_bus_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q,   gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q,  last_d;
    logic               busy_q,  busy_d;
    logic [TW-1:0]      turn_q,  turn_d;

    logic [IW-1:0]      cand;
    logic [OW-1:0]      pick_idx;
    logic               pick_vld;
    logic               hold_expired;

    // Rotating priority search: first requester after the last owner wins
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last_q} + IW'(i);
            if (cand >= C_N) begin
                cand = cand - C_N;
            end
            if (!pick_vld && req_i[cand[OW-1:0]]) begin
                pick_idx = cand[OW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    // Hold counter: zeroed while idle so it starts from 0 at each new grant
    always_comb begin
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == S_IDLE) begin
            hold_d = '0;
        end else if (state_q == S_GRANT) begin
            hold_d    = hold_q + 8'd1;
            timeout_d = hold_expired & req_i[owner_q];
        end
    end

    // Hold counter and timeout pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // hold_q counts completed grant cycles, so MAX_HOLD-1 means this is the last
    assign hold_expired = (hold_q == C_HOLD_LAST);
    assign timeout_o    = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // Next-state and registered-output logic of the arbitration FSM
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        busy_d  = busy_q;
        turn_d  = turn_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = C_ONE << pick_idx;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    busy_d  = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // Other requesters never pre-empt; only release or timeout end it
                if (!req_i[owner_q] || hold_expired) begin
                    gnt_d   = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                    turn_d  = '0;
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                if (turn_q == C_TURN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = '0;
                owner_d = '0;
                busy_d  = 1'b0;
                turn_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset parks the pointer so master 0 wins first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= C_LAST_RST;
            busy_q  <= 1'b0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign owner_o = owner_q;
    assign busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_bus_arbiter
// Description : Self-checking bench for rr_bus_arbiter. Directed scenarios
//               plus random request traffic, compared every cycle against a
//               transaction-level reference model of the arbitration rules.
//               Honours ARB_TIMEOUT_EN the same way the design does.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rr_bus_arbiter;

    localparam int N_REQ      = 4;
    localparam int TURNAROUND = 1;
    localparam int MAX_HOLD   = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       tout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: owner index (-1 = none), idle cycles still to
    // wait, last owner, cycles granted so far, timeout flag
    int m_owner = -1;
    int m_wait  = 0;
    int m_last  = N_REQ - 1;
    int m_len   = 0;
    bit m_tout  = 1'b0;

    // Scratch for directed tests
    int held[4];
    int order_q[$];
    int gap_q[$];

    always #5 clk = ~clk;

    rr_bus_arbiter #(
        .N_REQ      (N_REQ),
        .TURNAROUND (TURNAROUND),
        .MAX_HOLD   (MAX_HOLD)
    ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .owner_o   (owner),
        .busy_o    (busy),
        .timeout_o (tout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_wait  = 0;
        m_last  = N_REQ - 1;
        m_len   = 0;
        m_tout  = 1'b0;
    endtask

    // One bus cycle of the arbitration rules, using the requests seen at the edge
    task automatic model_edge(input logic [3:0] r);
        m_tout = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_wait  = TURNAROUND;
            end else if (TO_EN && m_len == MAX_HOLD) begin
                m_tout  = 1'b1;
                m_owner = -1;
                m_wait  = TURNAROUND;
            end else begin
                m_len++;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                int c;
                c = (m_last + k) % N_REQ;
                if (r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_len   = 1;
                    break;
                end
            end
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] g;
        logic [1:0] o;
        g = 4'b0000;
        o = 2'b00;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            o = 2'(m_owner);
        end
        return {g, o, (m_owner >= 0), m_tout};
    endfunction

    // Advance one clock, update the model, compare all outputs after the edge
    task automatic step(input string tag);
        @(posedge clk);
        model_edge(req);
        #1;
        check(tag, 32'({gnt, owner, busy, tout}), 32'(model_out()));
    endtask

    // Assert reset between edges, hold it over two edges, release mid-cycle
    task automatic do_reset(input logic [3:0] r);
        req = r;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_out", 32'({gnt, owner, busy, tout}), 32'd0);
        step("rst_hold");
        step("rst_hold");
        #2 rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag, output int who);
        who = -1;
        for (int i = 0; i < 40; i++) begin
            step(tag);
            if (busy) begin
                who = int'(owner);
                return;
            end
        end
        check({tag, "_no_grant"}, 32'(busy), 32'd1);
    endtask

    initial begin : main
        int         w;
        int         hi;
        int         len;
        int         tseen;
        int         gap;
        logic [3:0] prev;
        int         exp_ord[5];

        #3;
        // Reset with all masters requesting, then master 0 first
        do_reset(4'b1111);
        step("t1_first");
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_owner", 32'(owner), 32'd0);

        // Single requester for five cycles
        do_reset(4'b0000);
        req = 4'b0100;
        hi  = 0;
        for (int i = 0; i < 5; i++) begin
            step("t2");
            if (gnt == 4'b0100) hi++;
        end
        req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step("t2");
            if (gnt != 4'b0000) hi++;
        end
        check("t2_len", 32'(hi), 32'd5);

        // Rotation with every master requesting
        do_reset(4'b1111);
        foreach (held[i]) held[i] = 0;
        order_q.delete();
        gap_q.delete();
        gap  = 0;
        prev = 4'b0000;
        for (int cyc = 0; cyc < 200 && order_q.size() < 5; cyc++) begin
            step("t3");
            if (gnt == 4'b0000) gap++;
            if (gnt != 4'b0000 && prev == 4'b0000) begin
                if (order_q.size() > 0) gap_q.push_back(gap);
                order_q.push_back(int'(owner));
                gap = 0;
            end
            prev = gnt;
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    held[i]++;
                    if (held[i] == 3) req[i] = 1'b0;
                end else if (held[i] >= 3) begin
                    req[i]  = 1'b1;
                    held[i] = 0;
                end
            end
        end
        exp_ord = '{0, 1, 2, 3, 0};
        check("t3_count", 32'(order_q.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check("t3_order", (k < order_q.size()) ? 32'(order_q[k]) : 32'd99, 32'(exp_ord[k]));
        end
        foreach (gap_q[k]) check("t3_gap", 32'(gap_q[k]), 32'(TURNAROUND + 1));

        // Wrap-around: last owner 3 then requests 0 and 3 alternate
        do_reset(4'b1000);
        wait_grant("t4_setup", w);
        check("t4_setup", 32'(w), 32'd3);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) step("t4");
        req = 4'b1001;
        wait_grant("t4", w);
        check("t4_first", 32'(w), 32'd0);
        req[0] = 1'b0;
        step("t4");
        req[0] = 1'b1;
        wait_grant("t4", w);
        check("t4_second", 32'(w), 32'd3);
        req[3] = 1'b0;
        step("t4");
        req[3] = 1'b1;
        wait_grant("t4", w);
        check("t4_third", 32'(w), 32'd0);

        // Asynchronous reset in the middle of a grant
        do_reset(4'b0000);
        req = 4'b0100;
        wait_grant("t5", w);
        check("t5_owner", 32'(w), 32'd2);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("t5_async", 32'({gnt, busy}), 32'd0);
        #1 rst = 1'b0;
        wait_grant("t5", w);
        check("t5_regrant", 32'(w), 32'd2);

        // Long hold by master 1
        do_reset(4'b0000);
        req = 4'b0010;
        wait_grant("t6", w);
        len   = 1;
        tseen = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            step("t6");
            if (gnt[1]) len++;
            else begin
                tseen = int'(tout);
                break;
            end
        end
        check("t6_len", 32'(len), 32'(MAX_HOLD));
        check("t6_tout", 32'(tseen), 32'd1);
        gap = 1;
        for (int i = 0; i < 20; i++) begin
            step("t6");
            if (busy) break;
            gap++;
        end
        check("t6_regrant_gap", 32'(gap), 32'(TURNAROUND + 1));
`else
        for (int i = 0; i < 99; i++) begin
            step("t6");
            if (gnt[1]) len++;
            if (tout) tseen++;
        end
        check("t6_len", 32'(len), 32'd100);
        check("t6_tout", 32'(tseen), 32'd0);
`endif

        // Random request traffic with occasional asynchronous resets
        do_reset(4'b0000);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check("rnd_async", 32'({gnt, owner, busy, tout}), 32'(model_out()));
                #1 rst = 1'b0;
            end
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
